// File: rtl/rtpg_pkg.sv
// Shared types and helpers for the adaptive random test-pattern generator.
// The FSM state enum, the population count and the width helpers used to size counters.
package rtpg_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GEN   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        EVAL  = 3'd4,
        DONE  = 3'd5
    } rtpgState_t;

    // Bits needed to hold any value from 0 up to and including maxVal.
    function automatic int countWidth(input int maxVal);
        return $clog2(maxVal + 1);
    endfunction

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rtpg_lfsr.sv
// Galois LFSR (right-shifting) that produces candidate test vectors.
// Zero is never reachable: a zero seed is replaced by 1 on load.
module rtpg_lfsr #(
    parameter int               VEC_W = 6,
    parameter logic [VEC_W-1:0] TAPS  = VEC_W'(6'h30)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [VEC_W-1:0] seed,
    output logic [VEC_W-1:0] nextState
);

    logic [VEC_W-1:0] lfsrState;

    assign nextState = (lfsrState >> 1) ^ (lfsrState[0] ? TAPS : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsrState <= VEC_W'(1);
        end else if (load) begin
            lfsrState <= (seed == '0) ? VEC_W'(1) : seed;
        end else if (step) begin
            lfsrState <= nextState;
        end
    end

endmodule

// File: rtl/adaptive_rtpg.sv
// Adaptive random test-pattern generator: offers LFSR vectors to a fault engine, filters them
// against an adaptive expected-detection threshold and accumulates fault coverage.
module adaptive_rtpg
    import rtpg_pkg::*;
#(
    parameter int               VEC_W      = 6,
    parameter int               NUM_FAULTS = 16,
    parameter int               INIT_EXP   = 5,
    parameter int               UT_LIMIT   = 13,
    parameter int               COV_PCT    = 95,
    parameter logic [VEC_W-1:0] TAPS       = VEC_W'(6'h30),
    localparam int              CNT_W      = countWidth(UT_LIMIT)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [VEC_W-1:0]      seed,
    output logic                  vec_valid,
    input  logic                  vec_ready,
    output logic [VEC_W-1:0]      vec_out,
    input  logic                  resp_valid,
    input  logic [NUM_FAULTS-1:0] resp_map,
    output logic                  acc_valid,
    output logic [VEC_W-1:0]      acc_vec,
    output logic [CNT_W-1:0]      acc_idx,
    output logic                  busy,
    output logic                  done,
    output logic [6:0]            coverage,
    output logic [CNT_W-1:0]      tried
);

    localparam int CW = countWidth(NUM_FAULTS);

    rtpgState_t            state, stateNext;
    logic                  startHit;
    logic                  lfsrLoad, lfsrStep;
    logic [VEC_W-1:0]      lfsrNext;
    logic [NUM_FAULTS-1:0] covMap, respLatch, covMapNext;
    logic [CW-1:0]         expCnt, expNext, detCnt, newCnt;
    logic [CW:0]           expSum;
    logic                  accept, finish;
    logic [6:0]            covPctNew, covPctEval;

    assign startHit = start && ((state == IDLE) || (state == DONE));
    assign lfsrLoad = startHit;
    assign lfsrStep = (state == GEN);

    rtpg_lfsr #(
        .VEC_W (VEC_W),
        .TAPS  (TAPS)
    ) uLfsr (
        .clk       (clk),
        .rst       (rst),
        .load      (lfsrLoad),
        .step      (lfsrStep),
        .seed      (seed),
        .nextState (lfsrNext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = GEN;
            GEN:     stateNext = ISSUE;
            ISSUE:   if (vec_ready) stateNext = WAIT;
            WAIT:    if (resp_valid) stateNext = EVAL;
            EVAL:    stateNext = finish ? DONE : GEN;
            DONE:    if (start) stateNext = GEN;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        vec_valid = (state == ISSUE);
        busy      = (state == GEN) || (state == ISSUE) || (state == WAIT) || (state == EVAL);
        done      = (state == DONE);
    end

    // The threshold is updated first and the vector is judged against the updated value.
    always_comb begin
        detCnt     = CW'(popcount(64'(respLatch)));
        newCnt     = CW'(popcount(64'(respLatch & ~covMap)));
        expSum     = {1'b0, detCnt} + {1'b0, expCnt};
        expNext    = (detCnt < expCnt) ? (expCnt >> 1) : expSum[CW:1];
        accept     = (detCnt >= expNext) && (newCnt != '0);
        covMapNext = covMap | respLatch;
        covPctNew  = 7'((100 * popcount(64'(covMapNext))) / NUM_FAULTS);
        covPctEval = accept ? covPctNew : coverage;
        finish     = (covPctEval >= 7'(COV_PCT)) || (tried == CNT_W'(UT_LIMIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expCnt    <= CW'(INIT_EXP);
            covMap    <= '0;
            respLatch <= '0;
            coverage  <= '0;
            tried     <= '0;
            vec_out   <= '0;
            acc_valid <= 1'b0;
            acc_vec   <= '0;
            acc_idx   <= '0;
        end else begin
            acc_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        expCnt   <= CW'(INIT_EXP);
                        covMap   <= '0;
                        coverage <= '0;
                        tried    <= '0;
                    end
                end
                GEN: begin
                    vec_out <= lfsrNext;
                    tried   <= tried + 1'b1;
                end
                WAIT: begin
                    if (resp_valid) begin
                        respLatch <= resp_map;
                    end
                end
                EVAL: begin
                    expCnt <= expNext;
                    if (accept) begin
                        covMap    <= covMapNext;
                        coverage  <= covPctNew;
                        acc_valid <= 1'b1;
                        acc_vec   <= vec_out;
                        acc_idx   <= tried;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adaptive_rtpg.sv
// Self-checking bench for adaptive_rtpg: directed table rows, reset/busy corner cases and
// randomized engine responses compared against a per-candidate reference model.
module tb_adaptive_rtpg;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  seed;
    logic        vec_valid;
    logic        vec_ready;
    logic [5:0]  vec_out;
    logic        resp_valid;
    logic [15:0] resp_map;
    logic        acc_valid;
    logic [5:0]  acc_vec;
    logic [3:0]  acc_idx;
    logic        busy;
    logic        done;
    logic [6:0]  coverage;
    logic [3:0]  tried;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] seed;
        int         mode;
        int         hold;
        bit         directed;
        int         expTried;
        int         expCov;
        int         expAcc;
    } vecRow_t;

    vecRow_t     rows [8];
    logic [15:0] respTab [1:13];

    adaptive_rtpg dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .vec_out    (vec_out),
        .resp_valid (resp_valid),
        .resp_map   (resp_map),
        .acc_valid  (acc_valid),
        .acc_vec    (acc_vec),
        .acc_idx    (acc_idx),
        .busy       (busy),
        .done       (done),
        .coverage   (coverage),
        .tried      (tried)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [5:0] lfsrStep(input logic [5:0] s);
        return {1'b0, s[5:1]} ^ (s[0] ? 6'h30 : 6'h00);
    endfunction

    task automatic fillResp(input int mode);
        for (int i = 1; i <= 13; i++) begin
            case (mode)
                0:       respTab[i] = 16'hFFFF;
                1:       respTab[i] = 16'h000F;
                2:       respTab[i] = (i == 1) ? 16'h0003 : ((i == 2) ? 16'h00F0 : 16'h0000);
                default: respTab[i] = 16'($urandom & $urandom & $urandom);
            endcase
        end
    endtask

    // One full run; the reference model walks the candidate list with the adaptive filter rules.
    task automatic applyStimulus(input logic [5:0] sd, input int hold,
                                 output int nTried, output int nAcc, output int finalCov);
        logic [5:0]  lf;
        logic [15:0] cov;
        logic [15:0] map;
        int          expC, det, nw, pct, g;
        bit          acc, stop;
        lf = (sd == 6'd0) ? 6'd1 : sd;
        cov = '0;
        expC = 5;
        pct = 0;
        stop = 0;
        nTried = 0;
        nAcc = 0;
        seed = sd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_busy", busy, 1);
        for (int i = 1; i <= 13 && !stop; i++) begin
            lf = lfsrStep(lf);
            g = 0;
            while (!vec_valid && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (!vec_valid) begin
                checks++;
                errors++;
                $display("[TB] FAIL vec_valid_timeout actual=0 expected=1 candidate=%0d", i);
                finalCov = coverage;
                return;
            end
            checkOutput("vec_out", vec_out, lf);
            checkOutput("tried", tried, i);
            if (i == 1) begin
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    checkOutput("hold_valid", vec_valid, 1);
                    checkOutput("hold_vec", vec_out, lf);
                end
            end
            vec_ready = 1'b1;
            @(negedge clk);
            vec_ready = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            map = respTab[i];
            resp_map = map;
            resp_valid = 1'b1;
            @(negedge clk);
            resp_valid = 1'b0;
            @(negedge clk);
            det = $countones(map);
            nw = $countones(map & ~cov);
            expC = (det < expC) ? expC / 2 : (det + expC) / 2;
            acc = (det >= expC) && (nw > 0);
            if (acc) begin
                cov = cov | map;
                pct = (100 * $countones(cov)) / 16;
                nAcc++;
            end
            checkOutput("acc_valid", acc_valid, int'(acc));
            if (acc) begin
                checkOutput("acc_idx", acc_idx, i);
                checkOutput("acc_vec", acc_vec, lf);
            end
            checkOutput("coverage", coverage, pct);
            stop = (pct >= 95) || (i == 13);
            checkOutput("done", done, int'(stop));
            nTried = i;
        end
        checkOutput("end_busy", busy, 0);
        finalCov = coverage;
    endtask

    initial begin
        int nTried, nAcc, finalCov, g;
        clk = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        seed = '0;
        vec_ready = 1'b0;
        resp_valid = 1'b0;
        resp_map = '0;

        rows[0] = '{6'd1, 0, 0, 1'b1, 1, 100, 1};
        rows[1] = '{6'd1, 1, 0, 1'b1, 13, 25, 1};
        rows[2] = '{6'd1, 2, 0, 1'b1, 13, 37, 2};
        rows[3] = '{6'd0, 0, 0, 1'b1, 1, 100, 1};
        for (int r = 4; r < 8; r++) begin
            rows[r] = '{6'($urandom), 3, (r == 4) ? 20 : 0, 1'b0, 0, 0, 0};
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_vec_valid", vec_valid, 0);
        checkOutput("rst_vec_out", vec_out, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_coverage", coverage, 0);
        checkOutput("rst_tried", tried, 0);
        checkOutput("rst_acc_valid", acc_valid, 0);

        for (int r = 0; r < 4; r++) begin
            fillResp(rows[r].mode);
            applyStimulus(rows[r].seed, rows[r].hold, nTried, nAcc, finalCov);
            checkOutput($sformatf("row%0d_tried", r), nTried, rows[r].expTried);
            checkOutput($sformatf("row%0d_cov", r), finalCov, rows[r].expCov);
            checkOutput($sformatf("row%0d_accs", r), nAcc, rows[r].expAcc);
        end

        // Zero seed, start while busy, then reset in the middle of WAIT.
        seed = 6'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (!vec_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        checkOutput("seed0_first_vec", vec_out, 6'h30);
        checkOutput("seed0_tried", tried, 1);
        seed = 6'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_start_valid", vec_valid, 1);
        checkOutput("busy_start_vec", vec_out, 6'h30);
        checkOutput("busy_start_tried", tried, 1);
        vec_ready = 1'b1;
        @(negedge clk);
        vec_ready = 1'b0;
        @(negedge clk);
        checkOutput("wait_busy", busy, 1);
        checkOutput("wait_vec_valid", vec_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_tried", tried, 0);
        checkOutput("abort_vec_out", vec_out, 0);
        resp_map = 16'hFFFF;
        resp_valid = 1'b1;
        @(negedge clk);
        resp_valid = 1'b0;
        @(negedge clk);
        checkOutput("spurious_acc_valid", acc_valid, 0);
        checkOutput("spurious_busy", busy, 0);
        checkOutput("spurious_coverage", coverage, 0);
        checkOutput("spurious_done", done, 0);

        for (int r = 4; r < 8; r++) begin
            fillResp(rows[r].mode);
            applyStimulus(rows[r].seed, rows[r].hold, nTried, nAcc, finalCov);
            checkOutput($sformatf("row%0d_done", r), done, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
